// File: rtl/core_pkg.sv
// Shared definitions for the EX-stage divide controller: state encoding and default sizes.
package core_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 32;
    localparam int unsigned DONE_MASK_DEF = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StWb   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; gives |x| for operands and applies the sign to results.
module div_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU front/back end around an unsigned iterative divider, writing HI/LO.
// Optional macro DIV_ZERO_FAST_EN: divide by zero bypasses the divider (HI=rs, LO=all ones).
module div_ctrl
    import core_pkg::*;
#(
    parameter int unsigned DONE_MASK = DONE_MASK_DEF,
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_div_valid,
    input  logic                 ex_signed,
    input  logic [DIV_WIDTH-1:0] ex_rs,
    input  logic [DIV_WIDTH-1:0] ex_rt,
    input  logic                 flush,
    input  logic                 wb_ready,
    output logic [DIV_WIDTH-1:0] div_A,
    output logic [DIV_WIDTH-1:0] div_B,
    output logic                 div_start,
    input  logic [DIV_WIDTH-1:0] div_Q,
    input  logic [DIV_WIDTH-1:0] div_R,
    input  logic                 div_done,
    output logic                 div_stall,
    output logic                 hilo_we,
    output logic [DIV_WIDTH-1:0] hi_out,
    output logic [DIV_WIDTH-1:0] lo_out
);

    localparam int unsigned CntW = (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;
    localparam logic [CntW-1:0] DoneCnt = CntW'(DONE_MASK);

    div_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                 neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [DIV_WIDTH-1:0] rs_abs, rt_abs, q_fix, r_fix;
    logic                 rs_neg, rt_neg;

    assign rs_neg = ex_signed & ex_rs[DIV_WIDTH-1];
    assign rt_neg = ex_signed & ex_rt[DIV_WIDTH-1];

    div_sign_fix #(.WIDTH(DIV_WIDTH)) u_fix_a (.val(ex_rs), .neg(rs_neg),  .res(rs_abs));
    div_sign_fix #(.WIDTH(DIV_WIDTH)) u_fix_b (.val(ex_rt), .neg(rt_neg),  .res(rt_abs));
    div_sign_fix #(.WIDTH(DIV_WIDTH)) u_fix_q (.val(div_Q), .neg(neg_q_q), .res(q_fix));
    div_sign_fix #(.WIDTH(DIV_WIDTH)) u_fix_r (.val(div_R), .neg(neg_r_q), .res(r_fix));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        div_start = 1'b0;
        div_stall = 1'b0;
        hilo_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ex_div_valid && !flush) begin
                    div_stall = 1'b1;
                    a_d       = rs_abs;
                    b_d       = rt_abs;
                    neg_q_d   = ex_signed & (ex_rs[DIV_WIDTH-1] ^ ex_rt[DIV_WIDTH-1]);
                    neg_r_d   = rs_neg;
                    cnt_d     = '0;
                    state_d   = StBusy;
`ifdef DIV_ZERO_FAST_EN
                    if (ex_rt == '0) begin
                        hi_d    = ex_rs;
                        lo_d    = '1;
                        state_d = StWb;
                    end
`endif
                end
            end
            StBusy: begin
                div_start = 1'b1;
                div_stall = 1'b1;
                if (cnt_q != DoneCnt) cnt_d = cnt_q + 1'b1;
                // div_done may still be high from the previous op until the mask expires
                if (cnt_q == DoneCnt && div_done) begin
                    lo_d    = q_fix;
                    hi_d    = r_fix;
                    state_d = StWb;
                end
            end
            StWb: begin
                hilo_we   = wb_ready;
                div_stall = !wb_ready;
                if (wb_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d   = StIdle;
            div_start = 1'b0;
            hilo_we   = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign div_A  = a_q;
    assign div_B  = b_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
